// File: rtl/apb_multi_periph_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_multi_periph_bridge
// Purpose  : APB slave fronting NUM_CH peripheral cores with per-channel clock
//            gating, window decode, read wait states and sticky masked irq.
// Revision : 1.0
// ============================================================================

module ef_util_gating_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic gclk_o
);
    // Enable is captured while the clock is low so the AND never truncates a pulse.
    logic en_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) en_q <= 1'b0;
        else         en_q <= en_i;
    end

    assign gclk_o = clk_i & en_q;
endmodule

module apb_multi_periph_bridge #(
    parameter int NUM_CH     = 2,
    parameter int RD_WAIT    = 1,
    parameter int CH_SEL_LSB = 12
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [31:0]             PADDR,
    input  logic [31:0]             PWDATA,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    irq,
    output logic [NUM_CH-1:0]       ch_clk,
    output logic [NUM_CH-1:0]       ch_cs,
    output logic                    ch_rd,
    output logic                    ch_wr,
    output logic [CH_SEL_LSB-1:0]   ch_addr,
    output logic [31:0]             ch_wdata,
    input  logic [NUM_CH*32-1:0]    ch_rdata,
    input  logic [NUM_CH-1:0]       ch_irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic [3:0] C_RD_WAIT = 4'(RD_WAIT);

    state_t              state_q, state_d;
    logic                wr_q, wr_d, ctrl_q, ctrl_d, chan_q, chan_d;
    logic [7:0]          off_q, off_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]   oh_q, oh_d, gclk_q, gclk_d, im_q, im_d, ris_q, ris_d;
    logic [NUM_CH-1:0]   irq_prev_q, w_icr;
    logic                w_ctrl;
    logic [31:0]         w_idx, w_ch_rdata;
    logic [NUM_CH-1:0]   w_oh, w_en_oh;
    logic                w_unused;

    assign w_unused = &{1'b0, PADDR[31:16]};
    assign ch_addr  = PADDR[CH_SEL_LSB-1:0];
    assign ch_wdata = PWDATA;
    assign irq      = |(ris_q & im_q);

    always_comb begin
        w_ctrl = (PADDR[15:8] == 8'hFF);
        w_idx  = 32'(PADDR[15:0]) >> CH_SEL_LSB;
        w_oh   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_oh[n] = ~w_ctrl && (w_idx == 32'(n));
        end
        w_en_oh    = w_oh & gclk_q;
        w_ch_rdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (oh_q[n]) w_ch_rdata = w_ch_rdata | ch_rdata[32*n +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        ctrl_d  = ctrl_q;
        chan_d  = chan_q;
        off_d   = off_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        gclk_d  = gclk_q;
        im_d    = im_q;
        w_icr   = '0;
        PRDATA  = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        ch_cs   = '0;
        ch_rd   = 1'b0;
        ch_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    wr_d    = PWRITE;
                    ctrl_d  = w_ctrl;
                    chan_d  = |w_en_oh;
                    off_d   = PADDR[7:0];
                    oh_d    = w_en_oh;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                    // Reads are launched in setup so the core's data is ready by the access phase.
                    if (!PWRITE && (|w_en_oh)) begin
                        ch_cs = w_en_oh;
                        ch_rd = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (PENABLE) begin
                    if (ctrl_q) begin
                        PREADY  = 1'b1;
                        state_d = S_IDLE;
                        if (wr_q) begin
                            case (off_q)
                                8'h10:   gclk_d = PWDATA[NUM_CH-1:0];
                                8'h14:   im_d   = PWDATA[NUM_CH-1:0];
                                8'h1C:   w_icr  = PWDATA[NUM_CH-1:0];
                                default: ;
                            endcase
                        end else begin
                            case (off_q)
                                8'h10:   PRDATA = 32'(gclk_q);
                                8'h14:   PRDATA = 32'(im_q);
                                8'h18:   PRDATA = 32'(ris_q);
                                default: PRDATA = '0;
                            endcase
                        end
                    end else if (chan_q) begin
                        if (wr_q) begin
                            ch_cs   = oh_q;
                            ch_wr   = 1'b1;
                            PREADY  = 1'b1;
                            state_d = S_IDLE;
                        end else if (RD_WAIT == 0) begin
                            PREADY  = 1'b1;
                            PRDATA  = w_ch_rdata;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                            state_d = S_WAIT;
                        end
                    end else begin
                        PREADY  = 1'b1;
                        PSLVERR = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == C_RD_WAIT) begin
                    PREADY  = 1'b1;
                    PRDATA  = w_ch_rdata;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new rising edge outranks a clear landing in the same cycle.
        ris_d = (ris_q & ~w_icr) | (ch_irq & ~irq_prev_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            ctrl_q     <= 1'b0;
            chan_q     <= 1'b0;
            off_q      <= '0;
            oh_q       <= '0;
            cnt_q      <= '0;
            gclk_q     <= '0;
            im_q       <= '0;
            ris_q      <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            ctrl_q     <= ctrl_d;
            chan_q     <= chan_d;
            off_q      <= off_d;
            oh_q       <= oh_d;
            cnt_q      <= cnt_d;
            gclk_q     <= gclk_d;
            im_q       <= im_d;
            ris_q      <= ris_d;
            irq_prev_q <= ch_irq;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_gate
        ef_util_gating_cell u_gate (
            .clk_i  (PCLK),
            .rst_ni (PRESETn),
            .en_i   (gclk_q[g]),
            .gclk_o (ch_clk[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_periph_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_multi_periph_bridge
// Purpose  : Vector table plus scoreboard bench for apb_multi_periph_bridge.
// Revision : 1.0
// ============================================================================

module tb_apb_multi_periph_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn, PRESETn2;
    logic        PSEL, PSEL2, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA, PRDATA2;
    logic        PREADY, PREADY2, PSLVERR, PSLVERR2, irq, irq2;
    logic [1:0]  ch_clk, ch_clk2, ch_cs, ch_cs2, ch_irq, ch_irq2;
    logic        ch_rd, ch_rd2, ch_wr, ch_wr2;
    logic [11:0] ch_addr, ch_addr2;
    logic [31:0] ch_wdata, ch_wdata2;
    logic [63:0] ch_rdata;

    always #5 PCLK = ~PCLK;

    apb_multi_periph_bridge #(.NUM_CH(2), .RD_WAIT(1), .CH_SEL_LSB(12)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .irq(irq), .ch_clk(ch_clk), .ch_cs(ch_cs), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_irq(ch_irq)
    );

    apb_multi_periph_bridge #(.NUM_CH(2), .RD_WAIT(3), .CH_SEL_LSB(12)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn2), .PSEL(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2), .PSLVERR(PSLVERR2),
        .irq(irq2), .ch_clk(ch_clk2), .ch_cs(ch_cs2), .ch_rd(ch_rd2), .ch_wr(ch_wr2),
        .ch_addr(ch_addr2), .ch_wdata(ch_wdata2), .ch_rdata(ch_rdata), .ch_irq(ch_irq2)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          waits;
        int          nrd;
        int          nwr;
        logic [1:0]  cs;
    } vec_t;

    vec_t        tbl [16];
    logic [32:0] sb_q [$];
    int          errors = 0, checks = 0;
    int          rd_cnt = 0, wr_cnt = 0, rd2_cnt = 0, wr2_cnt = 0;
    logic [1:0]  rd_cs, wr_cs;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_cmp(input logic [31:0] rd, input logic err);
        logic [32:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got completion with no expected entry at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("prdata", rd, e[32:1]);
            check("pslverr", 32'(err), 32'(e[0]));
        end
    endtask

    always @(negedge PCLK) begin
        if (PSEL && PENABLE && PREADY)        sb_cmp(PRDATA, PSLVERR);
        else if (PSEL2 && PENABLE && PREADY2) sb_cmp(PRDATA2, PSLVERR2);
        if (PSEL && PENABLE && !PREADY) check("busy_resp", PRDATA | 32'(PSLVERR), 32'h0);
        if (ch_rd)  begin rd_cnt++; rd_cs = ch_cs; end
        if (ch_wr)  begin wr_cnt++; wr_cs = ch_cs; wr_addr = ch_addr; wr_data = ch_wdata; end
        if (ch_rd2) rd2_cnt++;
        if (ch_wr2) wr2_cnt++;
    end

    task automatic apb(input bit d2, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_err, input int exp_waits,
                       input logic [1:0] irq_set);
        int waits;
        bit done;
        @(posedge PCLK); #1;
        PADDR = addr; PWRITE = wr; PWDATA = wdata; PENABLE = 1'b0;
        if (d2) PSEL2 = 1'b1; else PSEL = 1'b1;
        sb_q.push_back({exp_rd, exp_err});
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        ch_irq  = ch_irq | irq_set;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (d2 ? PREADY2 : PREADY) done = 1'b1;
            else                      waits++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: got no PREADY expected within 40 cycles addr %h", addr);
            void'(sb_q.pop_back());
        end else begin
            check("wait_states", 32'(waits), 32'(exp_waits));
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_irq(input bit d2, input int bitn);
        @(posedge PCLK); #1;
        if (d2) ch_irq2[bitn] = 1'b1; else ch_irq[bitn] = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        if (d2) ch_irq2[bitn] = 1'b0; else ch_irq[bitn] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m_gclk;
        int r0, w0;
        PRESETn = 1'b0; PRESETn2 = 1'b0;
        PSEL = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ch_irq = '0; ch_irq2 = '0;
        ch_rdata = {32'hCAFE0001, 32'h11110000};
        m_gclk = 2'b00;

        //           wr    addr        wdata         rdata         err  w  rd wr cs
        tbl[0]  = '{1'b0, 32'hFF10, 32'h0,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[1]  = '{1'b0, 32'h1004, 32'h0,        32'h0,        1'b1, 0, 0, 0, 2'b00};
        tbl[2]  = '{1'b1, 32'hFF10, 32'h3,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[3]  = '{1'b0, 32'hFF10, 32'h0,        32'h3,        1'b0, 0, 0, 0, 2'b00};
        tbl[4]  = '{1'b0, 32'h1004, 32'h0,        32'hCAFE0001, 1'b0, 1, 1, 0, 2'b10};
        tbl[5]  = '{1'b1, 32'hFF10, 32'h1,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[6]  = '{1'b1, 32'h0020, 32'hDEADBEEF, 32'h0,        1'b0, 0, 0, 1, 2'b01};
        tbl[7]  = '{1'b0, 32'h3000, 32'h0,        32'h0,        1'b1, 0, 0, 0, 2'b00};
        tbl[8]  = '{1'b1, 32'h3000, 32'h5,        32'h0,        1'b1, 0, 0, 0, 2'b00};
        tbl[9]  = '{1'b0, 32'hFF30, 32'h0,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[10] = '{1'b1, 32'hFF14, 32'h2,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[11] = '{1'b0, 32'hFF14, 32'h0,        32'h2,        1'b0, 0, 0, 0, 2'b00};
        tbl[12] = '{1'b0, 32'hFF1C, 32'h0,        32'h0,        1'b0, 0, 0, 0, 2'b00};
        tbl[13] = '{1'b0, 32'h0008, 32'h0,        32'h11110000, 1'b0, 1, 1, 0, 2'b01};
        tbl[14] = '{1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 0, 0, 0, 2'b00};
        tbl[15] = '{1'b1, 32'h1000, 32'h7,        32'h0,        1'b1, 0, 0, 0, 2'b00};

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_outputs", {PRDATA[29:0], PREADY, PSLVERR},           32'h0);
        check("reset_strobes", {26'h0, irq, ch_cs, ch_rd, ch_wr, 1'b0},    32'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1; PRESETn2 = 1'b1;
        @(posedge PCLK); #2;
        check("reset_ch_clk", 32'(ch_clk), 32'h0);

        for (int i = 0; i < 16; i++) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            apb(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, tbl[i].waits, 2'b00);
            check("rd_pulses", 32'(rd_cnt - r0), 32'(tbl[i].nrd));
            check("wr_pulses", 32'(wr_cnt - w0), 32'(tbl[i].nwr));
            if (tbl[i].nrd != 0) check("rd_cs", 32'(rd_cs), 32'(tbl[i].cs));
            if (tbl[i].nwr != 0) begin
                check("wr_cs",    32'(wr_cs),   32'(tbl[i].cs));
                check("wr_addr",  32'(wr_addr), {20'h0, tbl[i].addr[11:0]});
                check("wr_wdata", wr_data,      tbl[i].wdata);
            end
            if (tbl[i].wr && tbl[i].addr[15:0] == 16'hFF10) m_gclk = tbl[i].wdata[1:0];
            @(posedge PCLK); #2;
            check("ch_clk", 32'(ch_clk), 32'(m_gclk));
        end

        // IM=0x2 from the table; channel 1 is gated but its irq is still sampled.
        pulse_irq(1'b0, 1);
        apb(1'b0, 1'b0, 32'hFF18, 32'h0, 32'h2, 1'b0, 0, 2'b00);
        @(negedge PCLK); check("irq_after_ch1", 32'(irq), 32'h1);
        pulse_irq(1'b0, 0);
        apb(1'b0, 1'b0, 32'hFF18, 32'h0, 32'h3, 1'b0, 0, 2'b00);
        @(negedge PCLK); check("irq_after_ch0", 32'(irq), 32'h1);
        apb(1'b0, 1'b1, 32'hFF1C, 32'h2, 32'h0, 1'b0, 0, 2'b10);
        apb(1'b0, 1'b0, 32'hFF18, 32'h0, 32'h3, 1'b0, 0, 2'b00);
        ch_irq = 2'b00;
        apb(1'b0, 1'b1, 32'hFF1C, 32'h3, 32'h0, 1'b0, 0, 2'b00);
        apb(1'b0, 1'b0, 32'hFF18, 32'h0, 32'h0, 1'b0, 0, 2'b00);
        @(negedge PCLK); check("irq_cleared", 32'(irq), 32'h0);

        // Second instance: load state, then reset in the middle of a waited read.
        apb(1'b1, 1'b1, 32'hFF10, 32'h1, 32'h0, 1'b0, 0, 2'b00);
        apb(1'b1, 1'b1, 32'hFF14, 32'h1, 32'h0, 1'b0, 0, 2'b00);
        pulse_irq(1'b1, 0);
        apb(1'b1, 1'b0, 32'h0010, 32'h0, 32'h11110000, 1'b0, 3, 2'b00);
        @(negedge PCLK); check("irq2_set", 32'(irq2), 32'h1);
        r0 = rd2_cnt;
        @(posedge PCLK); #1;
        PADDR = 32'h0; PWRITE = 1'b0; PSEL2 = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        check("abort_wait_low", 32'(PREADY2), 32'h0);
        #2;
        PRESETn2 = 1'b0;
        #1;
        check("abort_pready",  32'(PREADY2), 32'h0);
        check("abort_irq",     32'(irq2),    32'h0);
        check("abort_rd_once", 32'(rd2_cnt - r0), 32'h1);
        PSEL2 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn2 = 1'b1;
        r0 = rd2_cnt;
        w0 = wr2_cnt;
        repeat (4) @(posedge PCLK);
        #2;
        check("post_reset_ch_clk", 32'(ch_clk2), 32'h0);
        check("post_reset_strobes", 32'((rd2_cnt - r0) + (wr2_cnt - w0)), 32'h0);
        apb(1'b1, 1'b0, 32'hFF10, 32'h0, 32'h0, 1'b0, 0, 2'b00);
        apb(1'b1, 1'b0, 32'hFF14, 32'h0, 32'h0, 1'b0, 0, 2'b00);
        apb(1'b1, 1'b0, 32'hFF18, 32'h0, 32'h0, 1'b0, 0, 2'b00);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
